// File: rtl/timer_cnt_cmp.sv
// -----------------------------------------------------------------------------
// timer_cnt_cmp
//
// Free-running event counter with compare-match interrupt and debug halt.
// The counter advances on prescaler ticks while the timer is running, can be
// loaded by software at any time, and raises a sticky status bit whenever its
// value equals the compare register.
//
// Ports
//   i_clk        system clock, all state updates on the rising edge
//   i_rst        asynchronous active-high reset
//   i_cnt_pulse  one-cycle count tick from the prescaler
//   i_timer_en   timer enable level
//   i_cnt_wr     one-cycle software counter-write strobe
//   i_cnt_wdata  counter load value (sampled with i_cnt_wr)
//   i_cmp_val    compare value
//   i_int_en     interrupt output enable
//   i_int_clr    one-cycle write-1-to-clear strobe for o_int_st
//   i_halt_req   debug halt request level
//   o_halt_ack   high exactly while the timer is halted
//   o_cnt        current counter value
//   o_int_st     sticky compare-match status
//   o_interrupt  interrupt request (o_int_st gated by i_int_en)
// -----------------------------------------------------------------------------
module timer_cnt_cmp #(
    parameter int CNT_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cnt_pulse,
    input  logic                 i_timer_en,
    input  logic                 i_cnt_wr,
    input  logic [CNT_WIDTH-1:0] i_cnt_wdata,
    input  logic [CNT_WIDTH-1:0] i_cmp_val,
    input  logic                 i_int_en,
    input  logic                 i_int_clr,
    input  logic                 i_halt_req,
    output logic                 o_halt_ack,
    output logic [CNT_WIDTH-1:0] o_cnt,
    output logic                 o_int_st,
    output logic                 o_interrupt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t state;
    logic   match;

    // Plain modulo-2^CNT_WIDTH increment: all-ones wraps to zero, carry dropped.
    function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
        return v + CNT_ONE;
    endfunction

    assign match       = (o_cnt == i_cmp_val);
    assign o_interrupt = o_int_st & i_int_en;

    // Control FSM. Disabling the timer overrides any halt request; the
    // acknowledge is registered alongside the state so it tracks HALT exactly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            o_halt_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_timer_en && i_halt_req) begin
                        state      <= HALT;
                        o_halt_ack <= 1'b1;
                    end else if (i_timer_en) begin
                        state      <= RUN;
                        o_halt_ack <= 1'b0;
                    end
                end
                RUN: begin
                    if (!i_timer_en) begin
                        state      <= IDLE;
                        o_halt_ack <= 1'b0;
                    end else if (i_halt_req) begin
                        state      <= HALT;
                        o_halt_ack <= 1'b1;
                    end
                end
                HALT: begin
                    if (!i_timer_en) begin
                        state      <= IDLE;
                        o_halt_ack <= 1'b0;
                    end else if (!i_halt_req) begin
                        state      <= RUN;
                        o_halt_ack <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    o_halt_ack <= 1'b0;
                end
            endcase
        end
    end

    // Counter. The increment looks at the current state, so a tick arriving in
    // the same cycle as RUN->HALT still counts. A software write wins over a
    // coincident tick, and leaving RUN simply holds the value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_cnt_wr) begin
            o_cnt <= i_cnt_wdata;
        end else if ((state == RUN) && i_cnt_pulse) begin
            o_cnt <= cnt_inc(o_cnt);
        end
    end

    // Sticky match status. Set wins over clear, so the bit keeps re-setting
    // for as long as the match persists. i_int_en only gates the output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_int_st <= 1'b0;
        end else if (match) begin
            o_int_st <= 1'b1;
        end else if (i_int_clr) begin
            o_int_st <= 1'b0;
        end
    end

endmodule
